// File: rtl/router_reg.sv
// Datapath register stage of the 1x3 router: latches the header, steers bytes
// into the selected FIFO, and checks packet parity for router_fsm.
module router_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  output logic [DATA_W-1:0] dout,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              err
);

  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] header_byte_q, header_byte_d;
  logic [DATA_W-1:0] hold_byte_q, hold_byte_d;
  logic [DATA_W-1:0] int_parity_q, int_parity_d;
  logic [DATA_W-1:0] pkt_parity_q, pkt_parity_d;
  logic              parity_done_q, parity_done_d;
  logic              low_pkt_valid_q, low_pkt_valid_d;
  logic              err_q, err_d;
  logic              checked_q, checked_d;

  always_comb begin
    dout_d          = dout_q;
    header_byte_d   = header_byte_q;
    hold_byte_d     = hold_byte_q;
    int_parity_d    = int_parity_q;
    pkt_parity_d    = pkt_parity_q;
    parity_done_d   = parity_done_q;
    low_pkt_valid_d = low_pkt_valid_q;
    err_d           = err_q;
    checked_d       = checked_q;

    // Address 2'b11 names no port; keep the previous header.
    if (detect_add && pkt_valid && data_in[1:0] != 2'b11)
      header_byte_d = data_in;

    // A byte arriving while the FIFO is full is parked and replayed in LAF.
    if (lfd_state)                   dout_d = header_byte_q;
    else if (ld_state && !fifo_full) dout_d = data_in;
    else if (ld_state && fifo_full)  hold_byte_d = data_in;
    else if (laf_state)              dout_d = hold_byte_q;

    if (detect_add)                                     int_parity_d = '0;
    else if (lfd_state)                                 int_parity_d = int_parity_q ^ header_byte_q;
    else if (ld_state && pkt_valid && !full_state)      int_parity_d = int_parity_q ^ data_in;

    if (ld_state && !pkt_valid)
      pkt_parity_d = data_in;

    if (rst_int_reg)                  low_pkt_valid_d = 1'b0;
    else if (ld_state && !pkt_valid)  low_pkt_valid_d = 1'b1;

    if (detect_add)
      parity_done_d = 1'b0;
    else if ((ld_state && !fifo_full && !pkt_valid) ||
             (laf_state && low_pkt_valid_q && !parity_done_q))
      parity_done_d = 1'b1;

    // Compare once, the cycle after parity_done rises; hold until next header.
    if (detect_add) begin
      err_d     = 1'b0;
      checked_d = 1'b0;
    end else if (parity_done_q && !checked_q) begin
      err_d     = (int_parity_q != pkt_parity_q);
      checked_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout_q          <= '0;
      header_byte_q   <= '0;
      hold_byte_q     <= '0;
      int_parity_q    <= '0;
      pkt_parity_q    <= '0;
      parity_done_q   <= 1'b0;
      low_pkt_valid_q <= 1'b0;
      err_q           <= 1'b0;
      checked_q       <= 1'b0;
    end else begin
      dout_q          <= dout_d;
      header_byte_q   <= header_byte_d;
      hold_byte_q     <= hold_byte_d;
      int_parity_q    <= int_parity_d;
      pkt_parity_q    <= pkt_parity_d;
      parity_done_q   <= parity_done_d;
      low_pkt_valid_q <= low_pkt_valid_d;
      err_q           <= err_d;
      checked_q       <= checked_d;
    end
  end

  assign dout          = dout_q;
  assign parity_done   = parity_done_q;
  assign low_pkt_valid = low_pkt_valid_q;
  assign err           = err_q;

endmodule
